// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot rotating priority ring.
// Grants are registered and held until done, request drop, or the hold limit.
module rr_ring_arbiter #(
  parameter int N        = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  input  logic [N-1:0]         done,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_id,
  output logic                 busy,
  output logic                 expired
);

  localparam int IW = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [N-1:0]  ptr;
  logic [7:0]    hold_cnt;

  logic [IW-1:0] ptr_id;
  logic [IW-1:0] pick_id;
  logic [N-1:0]  pick;
  logic          found;
  logic [IW:0]   idx;

  logic          own_done;
  logic          own_req;
  logic          at_limit;
  logic          release_now;

  // Search upward from the ring position with wrap; the ptr bit wins ties.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    ptr_id  = '0;
    pick_id = '0;
    found   = 1'b0;
    idx     = '0;
    for (int i = 0; i < N; i++) begin
      if (ptr[i]) ptr_id = IW'(i);
    end
    for (int k = 0; k < N; k++) begin
      idx = {1'b0, ptr_id} + (IW+1)'(k);
      if (idx >= (IW+1)'(N)) idx = idx - (IW+1)'(N);
      if (!found && req[idx[IW-1:0]]) begin
        found   = 1'b1;
        pick_id = idx[IW-1:0];
      end
    end
    pick = found ? (N'(1) << pick_id) : '0;
  end

  // Only the current owner's request and done bits matter while granted.
  assign own_done    = done[gnt_id];
  assign own_req     = req[gnt_id];
  assign at_limit    = (hold_cnt == 8'(MAX_HOLD));
  assign release_now = own_done || !own_req || at_limit;

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rstn) begin
      state    <= IDLE;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      expired  <= 1'b0;
      ptr      <= N'(1);
      hold_cnt <= '0;
    end else begin
      expired <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state    <= GRANT;
            gnt      <= pick;
            gnt_id   <= pick_id;
            busy     <= 1'b1;
            hold_cnt <= 8'd1;
          end
        end
        GRANT: begin
          if (release_now) begin
            state    <= IDLE;
            gnt      <= '0;
            gnt_id   <= '0;
            busy     <= 1'b0;
            hold_cnt <= '0;
            // Owner drops to lowest priority: the bit above it becomes the head.
            ptr      <= {gnt[N-2:0], gnt[N-1]};
            expired  <= !own_done && own_req;
          end else begin
            hold_cnt <= hold_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
